// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl -- gated frequency counter.
//
// A free-running prescaler provides a square-wave gate. The block waits for a
// fresh rising edge of the gate, then counts rising edges of sig_in for as
// long as the gate stays high (2^(OFFSET-div) cycles). It then hands the count
// to a consumer through a valid/ready register.
//
// Parameters
//   PRE_WIDTH  prescaler width (must exceed OFFSET)
//   CNT_WIDTH  edge counter / result width
//   DIV_WIDTH  gate select width
//   OFFSET     prescaler bit used as the gate when div=0
//
// Ports
//   aclk, aresetn        clock, async active-low reset
//   enable               run back-to-back measurements while high
//   div                  gate select, sampled only when a window is armed
//   sig_in               signal under test, already synchronous to aclk
//   result/sat           count of the last window and its saturation flag
//   result_valid/ready   delivery handshake
//   busy                 FSM is not idle
//   seq                  8-bit load counter (only with FGC_SEQ_EN defined)
//
// Build option: define FGC_SEQ_EN to add the seq output.
module freq_gate_ctrl #(
  parameter int PRE_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  parameter int DIV_WIDTH = 5,
  parameter int OFFSET    = 26
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 sat,
  output logic                 busy
`ifdef FGC_SEQ_EN
  ,
  output logic [7:0]           seq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 sig_prev_q, sig_prev_d;
  logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 satf_q, satf_d;
  logic                 armed_q, armed_d;
  logic [CNT_WIDTH-1:0] result_q, result_d;
  logic                 sat_q, sat_d;
  logic                 rv_q, rv_d;
`ifdef FGC_SEQ_EN
  logic [7:0]           seq_q, seq_d;
`endif

  int   gate_idx;
  logic gate;
  logic edge_det;

  // Gate bit select; a select past OFFSET falls back to bit 0. The masked
  // reduction keeps every prescaler bit in use.
  always_comb begin
    gate_idx = (int'(div_l_q) > OFFSET) ? 0 : OFFSET - int'(div_l_q);
    gate     = |(pre_q & ({{(PRE_WIDTH-1){1'b0}}, 1'b1} << gate_idx));
  end

  assign edge_det = sig_in & ~sig_prev_q;

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q + 1'b1;
    sig_prev_d = sig_in;
    div_l_d    = div_l_q;
    cnt_d      = cnt_q;
    satf_d     = satf_q;
    armed_d    = armed_q;
    result_d   = result_q;
    sat_d      = sat_q;
    rv_d       = rv_q;
`ifdef FGC_SEQ_EN
    seq_d      = seq_q;
`endif

    // Completed handshake; a DONE reload below overrides this.
    if (rv_q && result_ready) rv_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ARM;
          div_l_d = div;
          cnt_d   = '0;
          satf_d  = 1'b0;
          armed_d = 1'b0;
        end
      end
      S_ARM: begin
        // A window opens only on a gate rise seen from inside ARM, so a
        // gate that is already high on entry is skipped.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gate && armed_q) begin
          state_d = S_COUNT;
          cnt_d   = CNT_WIDTH'(edge_det);
          satf_d  = 1'b0;
        end else if (!gate) begin
          armed_d = 1'b1;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (!gate) begin
          state_d = S_DONE;
        end else if (edge_det) begin
          if (&cnt_q) satf_d = 1'b1;
          else        cnt_d  = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!rv_q || result_ready) begin
          result_d = cnt_q;
          sat_d    = satf_q;
          rv_d     = 1'b1;
`ifdef FGC_SEQ_EN
          seq_d    = seq_q + 8'd1;
`endif
          if (enable) begin
            state_d = S_ARM;
            div_l_d = div;
            cnt_d   = '0;
            satf_d  = 1'b0;
            armed_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      sig_prev_q <= 1'b0;
      div_l_q    <= '0;
      cnt_q      <= '0;
      satf_q     <= 1'b0;
      armed_q    <= 1'b0;
      result_q   <= '0;
      sat_q      <= 1'b0;
      rv_q       <= 1'b0;
`ifdef FGC_SEQ_EN
      seq_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      sig_prev_q <= sig_prev_d;
      div_l_q    <= div_l_d;
      cnt_q      <= cnt_d;
      satf_q     <= satf_d;
      armed_q    <= armed_d;
      result_q   <= result_d;
      sat_q      <= sat_d;
      rv_q       <= rv_d;
`ifdef FGC_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign result       = result_q;
  assign sat          = sat_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);
`ifdef FGC_SEQ_EN
  assign seq          = seq_q;
`endif

endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 The block SHALL have parameter PRE_WIDTH, default 32, giving the free-running prescaler width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, giving the edge counter and result width.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 5, giving the gate divider select width.
REQ-004 The block SHALL have parameter OFFSET, default 26, giving the prescaler bit used as the gate when div=0.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: run continuous measurements while high.
REQ-008 The block SHALL have port div, input, DIV_WIDTH bits: gate select.
REQ-009 The block SHALL have port sig_in, input, 1 bit: the signal under test, already synchronous to aclk.
REQ-010 The block SHALL have port result, output, CNT_WIDTH bits: the edge count of the last completed window.
REQ-011 The block SHALL have port result_valid, output, 1 bit: result holds unconsumed data.
REQ-012 The block SHALL have port result_ready, input, 1 bit: the consumer accepts result.
REQ-013 The block SHALL have port sat, output, 1 bit: the edge count of the delivered result saturated.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The prescaler SHALL be a PRE_WIDTH-bit counter that increments every cycle, wraps modulo 2^PRE_WIDTH and never stops.
REQ-016 The gate SHALL be prescaler bit (OFFSET - div_l), evaluated combinationally, where div_l is the latched div; if div_l > OFFSET, bit 0 SHALL be used.
REQ-017 The rising edge SHALL be detected as sig_in AND NOT sig_prev, where sig_prev is sig_in registered one cycle.
REQ-018 The FSM SHALL have four states: IDLE, ARM, COUNT, DONE.
REQ-019 IDLE SHALL go to ARM when enable=1, latching div into div_l and clearing the edge counter on that transition.
REQ-020 ARM SHALL go to COUNT on the first cycle the gate is 1 after having been sampled 0; a gate already high on entry SHALL NOT start a window.
REQ-021 In COUNT, the edge counter SHALL increment in every cycle with gate=1 and a detected edge; at all-ones it SHALL hold and set an internal saturation flag.
REQ-022 COUNT SHALL go to DONE on the first cycle the gate is 0; an edge detected in that cycle SHALL NOT be counted.
REQ-023 In DONE, if result_valid=0 or result_ready=1, then on that edge result SHALL be loaded with the count, sat with the flag, and result_valid set to 1; the FSM SHALL then go to ARM (re-latching div, clearing the counter and flag) if enable=1, else to IDLE.
REQ-024 In DONE with result_valid=1 and result_ready=0, the FSM SHALL stall; result and sat SHALL remain stable.
REQ-025 The handshake SHALL complete on a cycle with result_valid=1 and result_ready=1; result_valid SHALL clear on the next edge unless DONE reloads it in that same cycle, in which case it stays 1 with the new data.
REQ-026 enable=0 in ARM or COUNT SHALL return the FSM to IDLE on the next edge, discard the partial count and leave result, sat and result_valid unchanged.
REQ-027 Changes to div outside the IDLE->ARM and DONE->ARM transitions SHALL have no effect on the current window.
REQ-028 A window SHALL last exactly 2^(OFFSET - div_l) cycles.

Reset
REQ-029 With aresetn=0, the prescaler, sig_prev, edge counter, saturation flag, div_l, result, sat and result_valid SHALL be 0, the state SHALL be IDLE and busy SHALL be 0, independent of aclk.
REQ-030 A reset during any state SHALL abort the measurement; after release, the first window SHALL begin only via IDLE->ARM->COUNT.

Configuration
REQ-031 When FGC_SEQ_EN is defined, the block SHALL add output seq, 8 bits, reset 0, which increments (wrapping 255->0) on each result load and changes in the same cycle as result.
REQ-032 When FGC_SEQ_EN is not defined, port seq and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset: with aresetn low mid-COUNT, all outputs read 0 and busy=0 with no aclk edge.
REQ-034 With OFFSET=4, div=0, sig_in toggling every cycle and enable=1: result=8, sat=0, result_valid=1, one result per 32 cycles.
REQ-035 With OFFSET=4, div=2 and the same stimulus: the window is 4 cycles and result=2; changing div mid-COUNT leaves the current result at 2.
REQ-036 With CNT_WIDTH=4, OFFSET=6, div=0 and sig_in toggling: result=15, sat=1.
REQ-037 Backpressure: with result_ready held low across two windows, the FSM stalls in DONE, result holds the first value and busy=1; when result_ready rises, the second value loads with result_valid still 1 (and seq +1 when FGC_SEQ_EN is defined).
REQ-038 Abort: dropping enable mid-COUNT goes to IDLE next cycle with no new result_valid and result unchanged.
